bcd_display_ctrl: RTL and testbench
===================================

# bcd_display_ctrl

Parametrised binary-to-decimal seven-segment display controller. Accepts an unsigned `WIDTH`-bit binary value, converts it to BCD with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the result across `N_DIGITS` common-anode digits. The block adds leading-zero blanking, per-digit decimal points and an overflow indication, and it holds the display glitch-free during conversion. It sits directly between datapath values and the board's `sseg`/`an` pins and replaces the fixed 4-bit, 3-digit display path.

## Interface

Parameters:
- `WIDTH`, 10: input value width, legal range 1..26.
- `N_DIGITS`, 3: number of physical digits, legal range 1..8.
- `REFRESH_BITS`, 16: prescaler width; each digit is active for 2^`REFRESH_BITS` cycles.
- `BLANK_LZ`, 1: 1 blanks leading zeros; 0 shows all digits.

Ports:
- `clk`  in  1  single system clock; all state is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `entrada`  in  `WIDTH`  unsigned binary value to display.
- `dp_en`  in  `N_DIGITS`  per-digit decimal point, active-high; bit i belongs to digit i, with digit 0 the least significant.
- `busy`  out  1  high while a conversion is in progress (states CONV and DONE).
- `sseg`  out  8  registered segment pattern, active-low; [7]=dp, [6:0]={a,b,c,d,e,f,g}.
- `an`  out  `N_DIGITS`  registered anode enables, active-low, one-hot.

## Operation

- Internal BCD width is `BCD_DIGITS` = (`WIDTH`*301)/1000+1 digits. The overflow limit is `LIMIT` = 10^`N_DIGITS`−1.
- Registers:
  - `shadow`: last captured value.
  - `shreg`: binary shift register.
  - `bcd`: working BCD register.
  - `cnt`: shift counter.
  - `disp`: committed digits, `N_DIGITS`×4 bits.
  - `ovf`: committed overflow flag.
  - `rcnt`: refresh prescaler.
  - `idx`: active digit.
- FSM states are IDLE, CONV and DONE.
  - IDLE: if `entrada` != `shadow`, load `shadow` and `shreg` from `entrada`, clear `bcd` and `cnt`, latch `ovf_n` = (`entrada` > `LIMIT`), and go to CONV. Otherwise stay in IDLE.
  - CONV: each cycle, add 3 to every BCD nibble ≥5, then shift {`bcd`,`shreg`} left by 1 and increment `cnt`. The cycle with `cnt`==`WIDTH`−1 performs the last shift and goes to DONE.
  - DONE: copy the low `N_DIGITS` nibbles of `bcd` into `disp`, copy `ovf_n` into `ovf`, and go to IDLE.
- Changes on `entrada` during CONV or DONE are not sampled. They are detected on return to IDLE because they differ from `shadow`.
- Digit pattern for digit i, evaluated from `disp`, `ovf` and `dp_en`:
  - If `ovf`=1: dash, [6:0]=7'b1111110.
  - Else, if `BLANK_LZ`=1, i>0, and nibbles i..`N_DIGITS`−1 are all zero: blank, [6:0]=7'h7F.
  - Otherwise: decimal glyph of nibble i. Glyphs are 0=7'h01, 1=7'h4F, 2=7'h12, 3=7'h06, 4=7'h4C, 5=7'h24, 6=7'h20, 7=7'h0F, 8=7'h00, 9=7'h04.
  - `sseg[7]` = ~`dp_en[i]`, applied in all three cases including blank and dash.
- Refresh:
  - `rcnt` increments every cycle and wraps.
  - When `rcnt` is all ones, `idx` advances; it wraps from `N_DIGITS`−1 to 0. With `N_DIGITS`=1, `idx` stays at 0.
- Each cycle, `an` ← ~(1<<`idx`) and `sseg` ← pattern(`idx`).

## Timing

- Reset values:
  - Registers: `state`=IDLE, `shadow`=0, `disp`=0, `ovf`=0, `cnt`=0, `rcnt`=0, `idx`=0.
  - Outputs: `busy`=0, `an`=all ones, `sseg`=8'hFF.
- The first edge after reset is released drives digit 0.
- Conversion latency:
  - A new value is seen by IDLE at edge t.
  - CONV occupies edges t+1..t+`WIDTH`.
  - DONE commits `disp` at edge t+`WIDTH`+1, so the glyph appears on `sseg` by t+`WIDTH`+2.
  - `busy` is high from t+1 through t+`WIDTH`+1.
- `disp` and `ovf` change only in DONE; the display never shows partial results.
- Reset mid-conversion aborts immediately. `disp` returns to 0 and a nonzero `entrada` is then reconverted from IDLE.
- `dp_en` is not latched and takes effect on the next `sseg` register update.

## Test plan

- Reset with `entrada`=0, `REFRESH_BITS`=2, `N_DIGITS`=3 -> `an`=3'b111, `sseg`=8'hFF on the first cycle. After that `an` cycles 110, 101, 011, 110, with 4 cycles per digit and 3'b110 first. `sseg` is 8'h81 on digit 0 and 8'hFF on digits 1 and 2.
- `entrada`=255, `WIDTH`=10 -> `busy` is high for 11 cycles. Afterwards digits 2, 1, 0 show 8'h92, 8'hA4, 8'hA4. With `BLANK_LZ`=0 and `entrada`=7, the digits show 8'h81, 8'h81, 8'h8F.
- `entrada`=999 -> all digits show 8'h84. `entrada`=1000 -> all digits show dashes, 8'hFE. `dp_en`=3'b010 with `entrada`=1000 -> digit 1 shows 8'h7E.
- `entrada` changes from 12 to 34 at the 3rd CONV cycle -> 12 is committed first and shown as 8'hCF, 8'h92 on digits 1, 0. Then a second conversion starts the cycle after DONE, and 34 is committed WIDTH+2 cycles later.
- Reset asserted mid-conversion of 500 -> `busy`=0 and `disp`=0 on the next edge. After reset is released with 500 still held, 500 displays WIDTH+2 cycles later.
- Sweep `entrada` 0..1023 with `N_DIGITS`=4 -> every committed `disp` equals the decimal value and `ovf` stays 0.

Source files
------------

// File: rtl/bcd_display_ctrl_if.sv
// Display controller bus: the value and decimal points go in, the busy flag
// and the registered segment/anode patterns come out.
interface bcd_display_ctrl_if #(
  parameter int WIDTH    = 10,
  parameter int N_DIGITS = 3
);
  logic [WIDTH-1:0]    entrada;
  logic [N_DIGITS-1:0] dp_en;
  logic                busy;
  logic [7:0]          sseg;
  logic [N_DIGITS-1:0] an;

  modport master (
    output entrada,
    output dp_en,
    input  busy,
    input  sseg,
    input  an
  );

  modport slave (
    input  entrada,
    input  dp_en,
    output busy,
    output sseg,
    output an
  );
endinterface

// File: rtl/bcd_display_ctrl.sv
// Binary-to-decimal seven-segment display controller.
// A sequential double-dabble engine converts a changed input value to BCD.
// The finished digits are committed in one step. A prescaled refresh scan
// multiplexes them across common-anode digits. The scan adds leading-zero
// blanking, per-digit decimal points and a dash pattern on overflow.
module bcd_display_ctrl #(
  parameter int WIDTH        = 10,
  parameter int N_DIGITS     = 3,
  parameter int REFRESH_BITS = 16,
  parameter int BLANK_LZ     = 1
) (
  input  logic               clk,
  input  logic               reset,
  bcd_display_ctrl_if.slave  bus
);

  function automatic logic [31:0] pow10_m1(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int k = 0; k < n; k++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

  localparam int BCD_DIGITS  = (WIDTH * 301) / 1000 + 1;
  // The working register is at least as wide as the display, so the commit
  // slice always exists even for very narrow inputs.
  localparam int WORK_DIGITS = (BCD_DIGITS > N_DIGITS) ? BCD_DIGITS : N_DIGITS;
  localparam int BW          = 4 * WORK_DIGITS;
  localparam int CNT_W       = $clog2(WIDTH + 1);
  localparam int IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [31:0]             LIMIT    = pow10_m1(N_DIGITS);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [IDX_W-1:0]        IDX_ONE  = IDX_W'(1);
  localparam logic [REFRESH_BITS-1:0] RCNT_ONE = REFRESH_BITS'(1);
  localparam logic [N_DIGITS-1:0]     AN_ONE   = N_DIGITS'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Double-dabble correction: every nibble of 5 or more gets 3 added before the shift.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < WORK_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h01;
      4'd1:    glyph = 7'h4F;
      4'd2:    glyph = 7'h12;
      4'd3:    glyph = 7'h06;
      4'd4:    glyph = 7'h4C;
      4'd5:    glyph = 7'h24;
      4'd6:    glyph = 7'h20;
      4'd7:    glyph = 7'h0F;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h04;
      default: glyph = 7'h7F;
    endcase
  endfunction

  logic [1:0]              state;
  logic [WIDTH-1:0]        shadow;
  logic [WIDTH-1:0]        shreg;
  logic [BW-1:0]           bcd;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf_n;
  logic [4*N_DIGITS-1:0]   disp;
  logic                    ovf;
  logic [REFRESH_BITS-1:0] rcnt;
  logic [IDX_W-1:0]        idx;
  logic [7:0]              sseg_r;
  logic [N_DIGITS-1:0]     an_r;

  logic                    start;
  logic [BW+WIDTH-1:0]     shifted;
  logic [3:0]              cur_nib;
  logic                    upper_zero;
  logic [6:0]              seg7;
  logic [7:0]              pattern;

  assign start    = (state == S_IDLE) && (bus.entrada != shadow);
  assign bus.busy = (state != S_IDLE);
  assign bus.sseg = sseg_r;
  assign bus.an   = an_r;

  // Corrected BCD and the binary remainder shift left together as one word.
  always_comb begin
    shifted = {add3(bcd), shreg} << 1;
  end

  // Conversion sequencer and committed display state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      shadow <= '0;
      cnt    <= '0;
      disp   <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shadow <= bus.entrada;
            cnt    <= '0;
            state  <= S_CONV;
          end
        end
        S_CONV: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) state <= S_DONE;
        end
        S_DONE: begin
          disp  <= bcd[4*N_DIGITS-1:0];
          ovf   <= ovf_n;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Conversion datapath; it is always loaded before use, so it carries no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      shreg <= bus.entrada;
      bcd   <= '0;
      ovf_n <= ({{(32-WIDTH){1'b0}}, bus.entrada} > LIMIT);
    end else if (state == S_CONV) begin
      bcd   <= shifted[BW+WIDTH-1:WIDTH];
      shreg <= shifted[WIDTH-1:0];
    end
  end

  // Segment pattern of the currently scanned digit.
  always_comb begin
    cur_nib    = disp[4*int'(idx) +: 4];
    upper_zero = 1'b1;
    for (int j = 0; j < N_DIGITS; j++) begin
      if (j >= int'(idx) && disp[4*j +: 4] != 4'd0) upper_zero = 1'b0;
    end
    if (ovf)
      seg7 = 7'h7E;
    else if (BLANK_LZ != 0 && idx != '0 && upper_zero)
      seg7 = 7'h7F;
    else
      seg7 = glyph(cur_nib);
    pattern = {~bus.dp_en[idx], seg7};
  end

  // Refresh scan: prescaler, digit index and the registered pin outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt   <= '0;
      idx    <= '0;
      an_r   <= '1;
      sseg_r <= 8'hFF;
    end else begin
      rcnt <= rcnt + RCNT_ONE;
      if (&rcnt) begin
        if (idx == IDX_LAST) idx <= '0;
        else                 idx <= idx + IDX_ONE;
      end
      an_r   <= ~(AN_ONE << idx);
      sseg_r <= pattern;
    end
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: scan order, glyphs, blanking,
// overflow dashes, decimal points, late input changes, reset abort and a
// full 10-bit sweep on a four-digit instance.
module tb_bcd_display_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  bcd_display_ctrl_if #(.WIDTH(10), .N_DIGITS(3)) ifa ();
  bcd_display_ctrl_if #(.WIDTH(10), .N_DIGITS(3)) ifb ();
  bcd_display_ctrl_if #(.WIDTH(10), .N_DIGITS(4)) ifc ();

  bcd_display_ctrl #(.WIDTH(10), .N_DIGITS(3), .REFRESH_BITS(2), .BLANK_LZ(1))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  bcd_display_ctrl #(.WIDTH(10), .N_DIGITS(3), .REFRESH_BITS(2), .BLANK_LZ(0))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));
  bcd_display_ctrl #(.WIDTH(10), .N_DIGITS(4), .REFRESH_BITS(2), .BLANK_LZ(1))
    dut_c (.clk(clk), .reset(reset), .bus(ifc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic busy_of(input int w);
    case (w)
      0:       return ifa.busy;
      1:       return ifb.busy;
      default: return ifc.busy;
    endcase
  endfunction

  // Wait (bounded) until the chosen instance's busy reaches lvl.
  task automatic wait_busy(input int w, input logic lvl, input string tag);
    int n;
    logic b;
    n = 0;
    do begin
      @(negedge clk);
      b = busy_of(w);
      n++;
    end while (b !== lvl && n < 60);
    chk(tag, {31'd0, b}, {31'd0, lvl});
  endtask

  // Wait (bounded) for digit k of instance w (0=a, 1=b) to be scanned and sample sseg.
  task automatic read_digit(input int w, input int k, output logic [7:0] v);
    int n;
    logic [2:0] an_now;
    logic [2:0] an_exp;
    an_exp = ~(3'b001 << k);
    n = 0;
    do begin
      @(negedge clk);
      an_now = (w == 0) ? ifa.an : ifb.an;
      n++;
    end while (an_now !== an_exp && n < 30);
    chk("digit_select", {29'd0, an_now}, {29'd0, an_exp});
    v = (w == 0) ? ifa.sseg : ifb.sseg;
  endtask

  task automatic chk_digits(input int w, input string tag, input logic [7:0] e2,
                            input logic [7:0] e1, input logic [7:0] e0);
    logic [7:0] v;
    read_digit(w, 2, v); chk({tag, "_d2"}, {24'd0, v}, {24'd0, e2});
    read_digit(w, 1, v); chk({tag, "_d1"}, {24'd0, v}, {24'd0, e1});
    read_digit(w, 0, v); chk({tag, "_d0"}, {24'd0, v}, {24'd0, e0});
  endtask

  initial begin
    int n;
    int d;
    logic [2:0] an_exp;
    logic [7:0] s_exp;
    logic [15:0] bcd_exp;
    logic [7:0] v;

    ifa.entrada = '0; ifa.dp_en = '0;
    ifb.entrada = '0; ifb.dp_en = '0;
    ifc.entrada = '0; ifc.dp_en = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_an",   {29'd0, ifa.an},   32'h7);
    chk("rst_sseg", {24'd0, ifa.sseg}, 32'hFF);
    chk("rst_busy", {31'd0, ifa.busy}, 32'h0);
    reset = 1'b0;

    // Scan order after reset with value 0: 4 cycles per digit, digit 0 first
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      d = ((c - 1) / 4) % 3;
      an_exp = ~(3'b001 << d);
      s_exp  = (d == 0) ? 8'h81 : 8'hFF;
      chk("scan_an",   {29'd0, ifa.an},   {29'd0, an_exp});
      chk("scan_sseg", {24'd0, ifa.sseg}, {24'd0, s_exp});
    end

    // 255: busy for WIDTH+1 cycles, then "255"; unblanked instance shows "007"
    ifa.entrada = 10'd255;
    ifb.entrada = 10'd7;
    wait_busy(0, 1'b1, "busy_rise_255");
    n = 1;
    do begin
      @(negedge clk);
      if (ifa.busy === 1'b1) n++;
    end while (ifa.busy === 1'b1 && n < 40);
    chk("busy_len_255", n, 11);
    chk_digits(0, "v255", 8'h92, 8'hA4, 8'hA4);
    chk_digits(1, "v007_nolz", 8'h81, 8'h81, 8'h8F);

    // 999 is the largest displayable value
    ifa.entrada = 10'd999;
    wait_busy(0, 1'b1, "busy_rise_999");
    wait_busy(0, 1'b0, "busy_fall_999");
    chk_digits(0, "v999", 8'h84, 8'h84, 8'h84);

    // 1000 overflows into dashes; decimal point still applies
    ifa.entrada = 10'd1000;
    wait_busy(0, 1'b1, "busy_rise_1000");
    wait_busy(0, 1'b0, "busy_fall_1000");
    chk_digits(0, "v1000", 8'hFE, 8'hFE, 8'hFE);
    ifa.dp_en = 3'b010;
    chk_digits(0, "v1000_dp", 8'hFE, 8'h7E, 8'hFE);
    ifa.dp_en = 3'b000;

    // Change from 12 to 34 during conversion: 12 commits first, 34 WIDTH+2 later
    ifa.entrada = 10'd12;
    ifb.entrada = 10'd12;
    wait_busy(0, 1'b1, "busy_rise_12");
    repeat (2) @(negedge clk);
    ifa.entrada = 10'd34;
    wait_busy(0, 1'b0, "busy_fall_12");
    chk("disp_12", {20'd0, dut_a.disp}, 32'h012);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ifa.busy !== 1'b0 && n < 40);
    chk("relatch_gap", n, 12);
    chk("disp_34", {20'd0, dut_a.disp}, 32'h034);
    chk_digits(0, "v34", 8'hFF, 8'h86, 8'hCC);
    chk_digits(1, "v12_nolz", 8'h81, 8'hCF, 8'h92);

    // Reset mid-conversion of 500 aborts; 500 reconverts after release
    ifa.entrada = 10'd500;
    wait_busy(0, 1'b1, "busy_rise_500");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, ifa.busy},  32'h0);
    chk("abort_disp", {20'd0, dut_a.disp}, 32'h0);
    chk("abort_an",   {29'd0, ifa.an},     32'h7);
    chk("abort_sseg", {24'd0, ifa.sseg},   32'hFF);
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dut_a.disp !== 12'h500 && n < 40);
    chk("reconv_latency", n, 12);
    chk_digits(0, "v500", 8'hA4, 8'h81, 8'h81);

    // Sweep 0..1023 on the four-digit instance
    for (int val = 0; val < 1024; val++) begin
      ifc.entrada = 10'(val);
      if (val != 0) begin
        wait_busy(2, 1'b1, "sweep_rise");
        wait_busy(2, 1'b0, "sweep_fall");
      end else begin
        @(negedge clk);
      end
      bcd_exp = {4'(val / 1000), 4'((val / 100) % 10), 4'((val / 10) % 10), 4'(val % 10)};
      chk($sformatf("sweep_%0d", val), {15'd0, dut_c.ovf, dut_c.disp}, {16'd0, bcd_exp});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
